// File: rtl/enemy_spawn_gen.sv
// Enemy respawn Y generator: LFSR draw with rejection sampling, valid/ready output.
// Optional macro SPAWN_MIN_GAP_EN enforces a minimum distance between consecutive spawns.
module enemy_spawn_gen #(
    parameter int unsigned POS_W   = 12,
    parameter int unsigned X_EDGE  = 30,
    parameter int unsigned Y_MIN   = 130,
    parameter int unsigned Y_MAX   = 630,
    parameter int unsigned Y_INIT  = 350,
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int unsigned MAX_TRY = 8,
    parameter int unsigned MIN_GAP = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [POS_W-1:0] enemy_x,
    input  logic             pos_ready,
    output logic             pos_valid,
    output logic [POS_W-1:0] spawn_y,
    output logic             busy,
    output logic             fallback
);

    localparam int unsigned RANGE = Y_MAX - Y_MIN + 1;
    localparam int unsigned CW    = $clog2(RANGE);

    localparam logic [POS_W-1:0] XEdgeP  = POS_W'(X_EDGE);
    localparam logic [POS_W-1:0] YMinP   = POS_W'(Y_MIN);
    localparam logic [POS_W-1:0] YMidP   = POS_W'((Y_MIN + Y_MAX) / 2);
    localparam logic [POS_W-1:0] YInitP  = POS_W'(Y_INIT);
    localparam logic [POS_W-1:0] MinGapP = POS_W'(MIN_GAP);
    localparam logic [CW:0]      RangeP  = (CW + 1)'(RANGE);
    localparam logic [7:0]       LastTry = 8'(MAX_TRY - 1);

`ifdef SPAWN_MIN_GAP_EN
    localparam bit GapOn = 1'b1;
`else
    localparam bit GapOn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StDraw, StHold} state_t;

    state_t           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [POS_W-1:0] spawn_y_q, spawn_y_d;
    logic             pos_valid_q, pos_valid_d;
    logic             fallback_q, fallback_d;
    logic             pending_q, pending_d;
    logic [7:0]       try_cnt_q, try_cnt_d;
    logic             x_le_q;

    logic             x_le, trig;
    logic [CW-1:0]    cand;
    logic [POS_W-1:0] result, diff, fb_value;
    logic             in_range, gap_ok, accept;

    // Fibonacci taps 16,14,13,11; an all-zero state is recovered from SEED.
    assign lfsr_d = (lfsr_q == 16'd0) ? SEED
                                       : {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    assign x_le = (enemy_x <= XEdgeP);
    assign trig = x_le & ~x_le_q;

    assign cand     = lfsr_q[CW-1:0];
    assign in_range = ({1'b0, cand} < RangeP);
    assign result   = YMinP + POS_W'(cand);
    assign diff     = (result >= spawn_y_q) ? (result - spawn_y_q) : (spawn_y_q - result);
    assign gap_ok   = (diff >= MinGapP);
    assign accept   = in_range & (~GapOn | gap_ok);
    // With the gap check on, a fallback must still move away from the previous spawn.
    assign fb_value = (GapOn && spawn_y_q == YMidP) ? YMinP : YMidP;

    always_comb begin
        state_d     = state_q;
        spawn_y_d   = spawn_y_q;
        pos_valid_d = pos_valid_q;
        fallback_d  = fallback_q;
        pending_d   = pending_q;
        try_cnt_d   = try_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (trig) begin
                    state_d   = StDraw;
                    try_cnt_d = 8'd0;
                end
            end
            StDraw: begin
                if (trig) pending_d = 1'b1;
                if (accept) begin
                    spawn_y_d   = result;
                    fallback_d  = 1'b0;
                    pos_valid_d = 1'b1;
                    state_d     = StHold;
                end else if (try_cnt_q == LastTry) begin
                    spawn_y_d   = fb_value;
                    fallback_d  = 1'b1;
                    pos_valid_d = 1'b1;
                    state_d     = StHold;
                end else begin
                    try_cnt_d = try_cnt_q + 8'd1;
                end
            end
            StHold: begin
                if (pos_valid_q && pos_ready) begin
                    pos_valid_d = 1'b0;
                    try_cnt_d   = 8'd0;
                    pending_d   = 1'b0;
                    state_d     = (pending_q || trig) ? StDraw : StIdle;
                end else if (trig) begin
                    pending_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            lfsr_q      <= SEED;
            spawn_y_q   <= YInitP;
            pos_valid_q <= 1'b0;
            fallback_q  <= 1'b0;
            pending_q   <= 1'b0;
            try_cnt_q   <= 8'd0;
            x_le_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            spawn_y_q   <= spawn_y_d;
            pos_valid_q <= pos_valid_d;
            fallback_q  <= fallback_d;
            pending_q   <= pending_d;
            try_cnt_q   <= try_cnt_d;
            x_le_q      <= x_le;
        end
    end

    assign pos_valid = pos_valid_q;
    assign spawn_y   = spawn_y_q;
    assign busy      = (state_q != StIdle);
    assign fallback  = fallback_q;

endmodule

// File: tb/tb_enemy_spawn_gen.sv
// Directed bench for enemy_spawn_gen: vector table plus reset, pending and fallback sequences.
module tb_enemy_spawn_gen;

    localparam int          MAX_TRY = 8;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] enemy_x;
    logic        pos_ready;
    logic        pos_valid, busy, fallback;
    logic [11:0] spawn_y;

    logic [11:0] x2;
    logic        valid2, busy2, fb2;
    logic [11:0] y2;

    int checks = 0;
    int errors = 0;
    logic [15:0] m_lfsr;
    logic [11:0] last_y;

    enemy_spawn_gen dut (
        .clk       (clk),
        .rst       (rst),
        .enemy_x   (enemy_x),
        .pos_ready (pos_ready),
        .pos_valid (pos_valid),
        .spawn_y   (spawn_y),
        .busy      (busy),
        .fallback  (fallback)
    );

    // Single-draw instance: any out-of-range candidate goes straight to fallback.
    enemy_spawn_gen #(.MAX_TRY(1)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .enemy_x   (x2),
        .pos_ready (1'b1),
        .pos_valid (valid2),
        .spawn_y   (y2),
        .busy      (busy2),
        .fallback  (fb2)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        if (l == 16'd0) return SEED;
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Reference LFSR, advanced on the same edges as the DUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic predict(input logic [15:0] l_in, input logic [11:0] prev,
                           output logic [11:0] y, output logic fb, output int tries);
        logic [15:0] l;
        logic [8:0]  cand;
        int          val, d;
        bit          ok, done;
        l = l_in; done = 0; tries = 0; y = 12'd380; fb = 1'b1;
        for (int i = 0; i < MAX_TRY; i++) begin
            if (!done) begin
                tries = i + 1;
                cand  = l[8:0];
                val   = 130 + int'(cand);
                ok    = (cand < 9'd501);
`ifdef SPAWN_MIN_GAP_EN
                d  = (val >= int'(prev)) ? val - int'(prev) : int'(prev) - val;
                ok = ok && (d >= 100);
`else
                d  = 0;
`endif
                if (ok) begin
                    y = 12'(val); fb = 1'b0; done = 1;
                end
                l = lfsr_step(l);
            end
        end
`ifdef SPAWN_MIN_GAP_EN
        if (!done && prev == 12'd380) y = 12'd130;
`endif
    endtask

    // Called on the negedge where the trigger was applied (cnt0=0) or one cycle later (cnt0=1).
    task automatic wait_valid(input string tag, input logic [15:0] l, input int cnt0);
        logic [11:0] ey;
        logic        efb;
        int          et, cnt;
        predict(l, last_y, ey, efb, et);
        cnt = cnt0;
        while (pos_valid !== 1'b1 && cnt < MAX_TRY + 4) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_latency"}, cnt, et + 1);
        check({tag, "_spawn_y"}, int'(spawn_y), int'(ey));
        check({tag, "_fallback"}, int'(fallback), int'(efb));
        check({tag, "_in_range"}, int'(spawn_y >= 12'd130 && spawn_y <= 12'd630), 1);
        last_y = ey;
    endtask

    task automatic hold_stable(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, "_hold_y"}, int'(spawn_y), int'(last_y));
            check({tag, "_hold_valid"}, int'(pos_valid), 1);
        end
    endtask

    task automatic handshake(input string tag);
        pos_ready = 1'b1;
        @(negedge clk);
        pos_ready = 1'b0;
        check({tag, "_valid_drop"}, int'(pos_valid), 0);
    endtask

    typedef struct {
        logic [11:0] x_prev;
        logic [11:0] x_new;
        int          hold;
        bit          exp_trig;
    } vec_t;

    vec_t        vecs[8];
    logic [15:0] l, nx;
    int          cnt;
    bit          found;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{12'd31,   12'd30, 0,  1'b1};
        vecs[1] = '{12'd30,   12'd30, 0,  1'b0};
        vecs[2] = '{12'd500,  12'd0,  3,  1'b1};
        vecs[3] = '{12'd0,    12'd0,  0,  1'b0};
        vecs[4] = '{12'd4095, 12'd31, 0,  1'b0};
        vecs[5] = '{12'd31,   12'd29, 20, 1'b1};
        vecs[6] = '{12'd200,  12'd30, 1,  1'b1};
        vecs[7] = '{12'd32,   12'd31, 0,  1'b0};

        enemy_x = 12'd0; x2 = 12'd31; pos_ready = 1'b0; last_y = 12'd350;
        #1 rst = 1'b1;
        #2;
        check("rst_spawn_y", int'(spawn_y), 350);
        check("rst_valid", int'(pos_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_fallback", int'(fallback), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        // enemy_x already at the edge out of reset: must not trigger.
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (pos_valid || busy) cnt++;
        end
        check("no_trig_after_rst", cnt, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            enemy_x = vecs[i].x_prev;
            repeat (2) @(negedge clk);
            check($sformatf("v%0d_idle", i), int'(busy), 0);
            enemy_x = vecs[i].x_new;
            l = lfsr_step(m_lfsr);
            if (vecs[i].exp_trig) begin
                wait_valid($sformatf("v%0d", i), l, 0);
                hold_stable($sformatf("v%0d", i), vecs[i].hold);
                handshake($sformatf("v%0d", i));
            end else begin
                cnt = 0;
                repeat (MAX_TRY + 2) begin
                    @(negedge clk);
                    if (pos_valid || busy) cnt++;
                end
                check($sformatf("v%0d_no_trig", i), cnt, 0);
            end
        end

        // Pending queue: second edge during HOLD is served, third is dropped.
        @(negedge clk); enemy_x = 12'd31;
        @(negedge clk); enemy_x = 12'd30;
        l = lfsr_step(m_lfsr);
        wait_valid("pend1", l, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("pend_hold_y", int'(spawn_y), int'(last_y));
            check("pend_hold_valid", int'(pos_valid), 1);
            if (i == 5 || i == 10) enemy_x = 12'd31;
            if (i == 6 || i == 11) enemy_x = 12'd30;
        end
        pos_ready = 1'b1;
        l = lfsr_step(m_lfsr);
        @(negedge clk);
        pos_ready = 1'b0;
        check("pend_valid_drop", int'(pos_valid), 0);
        check("pend_busy_served", int'(busy), 1);
        wait_valid("pend2", l, 1);
        handshake("pend2");
        pos_ready = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (pos_valid) cnt++;
        end
        pos_ready = 1'b0;
        check("pend_third_dropped", cnt, 0);

        // Short random-ready run.
        for (int r = 0; r < 15; r++) begin
            @(negedge clk); enemy_x = 12'd31;
            @(negedge clk); enemy_x = 12'd30;
            l = lfsr_step(m_lfsr);
            wait_valid($sformatf("rnd%0d", r), l, 0);
            hold_stable($sformatf("rnd%0d", r), int'($urandom_range(0, 5)));
            handshake($sformatf("rnd%0d", r));
        end

        // Mid-cycle reset while holding a position.
        @(negedge clk); enemy_x = 12'd31;
        @(negedge clk); enemy_x = 12'd30;
        l = lfsr_step(m_lfsr);
        wait_valid("abort", l, 0);
        #2 rst = 1'b1;
        #1;
        check("abort_spawn_y", int'(spawn_y), 350);
        check("abort_valid", int'(pos_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_fallback", int'(fallback), 0);
        @(negedge clk);
        rst = 1'b0;
        last_y = 12'd350;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (pos_valid || busy) cnt++;
        end
        check("abort_quiet", cnt, 0);

        // Fallback: trigger dut2 exactly when its single draw is out of range.
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            nx = lfsr_step(m_lfsr);
            if (nx[8:0] >= 9'd501) begin
                x2 = 12'd30;
                found = 1;
            end
        end
        check("fb_window_found", int'(found), 1);
        @(negedge clk);
        check("fb_busy_draw", int'(busy2), 1);
        check("fb_not_yet_valid", int'(valid2), 0);
        @(negedge clk);
        check("fb_valid", int'(valid2), 1);
        check("fb_spawn_y", int'(y2), 380);
        check("fb_flag", int'(fb2), 1);
        @(negedge clk);
        check("fb_valid_drop", int'(valid2), 0);
        check("fb_y_kept", int'(y2), 380);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
